// File: rtl/dmc_dma_unit.sv
`default_nettype none
// ============================================================================
// Module  : dmc_dma_unit
// Brief   : DMC sample-fetch responder: halts the CPU, does one bus read,
//           returns the byte with a one-clock completion strobe.
// Revision: 1.0 - initial release
// ============================================================================
module dmc_dma_unit #(
    parameter bit ALIGN_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_en,
    input  logic        cpu_read,
    input  logic        get_cycle,
    input  logic        dma_read,
    input  logic [15:0] dma_addr,
    output logic [7:0]  dma_rdata,
    output logic        dma_done,
    output logic        rdy,
    output logic        bus_read,
    output logic [15:0] bus_addr,
    input  logic [7:0]  bus_rdata,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        DUMMY = 3'd2,
        ALIGN = 3'd3,
        GET   = 3'd4
    } state_t;

    state_t state;
    state_t state_next;
    logic   fetch_now;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else if (cpu_en) begin
            state <= state_next;
        end
    end

    // A request drop is honoured only before the halt has committed to the read.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (dma_read) begin
                    state_next = HALT;
                end
            end
            HALT: begin
                if (!dma_read) begin
                    state_next = IDLE;
                end else if (cpu_read) begin
                    state_next = DUMMY;
                end
            end
            DUMMY: begin
                if (!dma_read) begin
                    state_next = IDLE;
                end else if (ALIGN_EN && !get_cycle) begin
                    state_next = ALIGN;
                end else begin
                    state_next = GET;
                end
            end
            ALIGN:   state_next = GET;
            GET:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign fetch_now = cpu_en && (state == GET);

    // dma_done is a single-clock strobe: it clears on the following edge even if cpu_en is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dma_done  <= 1'b0;
            dma_rdata <= 8'h00;
        end else begin
            dma_done <= fetch_now;
            if (fetch_now) begin
                dma_rdata <= bus_rdata;
            end
        end
    end

    assign rdy      = (state == IDLE);
    assign busy     = ~rdy;
    assign bus_read = (state == GET);
    assign bus_addr = bus_read ? dma_addr : 16'h0000;

endmodule
`default_nettype wire

// File: tb/tb_dmc_dma_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmc_dma_unit
// Brief   : Self-checking bench for dmc_dma_unit (ALIGN_EN=1 and ALIGN_EN=0).
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmc_dma_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_en = 1'b0;
    logic        cpu_read = 1'b0;
    logic        get_cycle = 1'b0;
    logic        req_a = 1'b0;
    logic        req_b = 1'b0;
    logic [15:0] dma_addr = 16'h0000;
    logic [7:0]  bus_rdata = 8'h00;

    logic [7:0]  rdata_a, rdata_b;
    logic        done_a, done_b, rdy_a, rdy_b, br_a, br_b, busy_a, busy_b;
    logic [15:0] ba_a, ba_b;

    int checks = 0;
    int errors = 0;
    int low_a = 0, low_b = 0, rd_a = 0, rd_b = 0, dn_a = 0, dn_b = 0;
    logic [15:0] last_addr_a = 16'h0000;

    always #5 clk = ~clk;

    dmc_dma_unit #(.ALIGN_EN(1'b1)) dut_a (
        .clk(clk), .reset(reset), .cpu_en(cpu_en), .cpu_read(cpu_read),
        .get_cycle(get_cycle), .dma_read(req_a), .dma_addr(dma_addr),
        .dma_rdata(rdata_a), .dma_done(done_a), .rdy(rdy_a), .bus_read(br_a),
        .bus_addr(ba_a), .bus_rdata(bus_rdata), .busy(busy_a)
    );

    dmc_dma_unit #(.ALIGN_EN(1'b0)) dut_b (
        .clk(clk), .reset(reset), .cpu_en(cpu_en), .cpu_read(cpu_read),
        .get_cycle(get_cycle), .dma_read(req_b), .dma_addr(dma_addr),
        .dma_rdata(rdata_b), .dma_done(done_b), .rdy(rdy_b), .bus_read(br_b),
        .bus_addr(ba_b), .bus_rdata(bus_rdata), .busy(busy_b)
    );

    // Model: a fetch is "busy" from acceptance; once the halt lands, the read
    // happens a fixed number of CPU cycles later (1, or 2 when alignment is needed).
    typedef struct {
        bit         busy;
        bit         landed;
        int         step;
        int         get_step;
        bit         done;
        logic [7:0] rdata;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mreset();
        mdl_t m;
        m.busy = 0; m.landed = 0; m.step = 0; m.get_step = 1; m.done = 0; m.rdata = 8'h00;
        return m;
    endfunction

    function automatic mdl_t mstep(mdl_t m, bit en, bit req, bit cr, bit gc, bit align, logic [7:0] bd);
        mdl_t n = m;
        n.done = 0;
        if (en) begin
            if (!m.busy) begin
                if (req) begin n.busy = 1; n.landed = 0; end
            end else if (!m.landed) begin
                if (!req) n.busy = 0;
                else if (cr) begin n.landed = 1; n.step = 0; end
            end else if (m.step == 0) begin
                if (!req) begin n.busy = 0; n.landed = 0; end
                else begin n.get_step = (align && !gc) ? 2 : 1; n.step = 1; end
            end else if (m.step == m.get_step) begin
                n.rdata = bd; n.done = 1; n.busy = 0; n.landed = 0;
            end else begin
                n.step = m.step + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ma = mreset();
            mb = mreset();
        end else begin
            ma = mstep(ma, cpu_en, req_a, cpu_read, get_cycle, 1'b1, bus_rdata);
            mb = mstep(mb, cpu_en, req_b, cpu_read, get_cycle, 1'b0, bus_rdata);
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input string n, input mdl_t m, input logic rdy, input logic busy,
                       input logic br, input logic [15:0] ba, input logic done, input logic [7:0] rd);
        bit exp_br;
        exp_br = m.busy && m.landed && (m.step != 0) && (m.step == m.get_step);
        chk({n, ".rdy"}, {15'd0, rdy}, {15'd0, !m.busy});
        chk({n, ".busy"}, {15'd0, busy}, {15'd0, m.busy});
        chk({n, ".bus_read"}, {15'd0, br}, {15'd0, exp_br});
        chk({n, ".bus_addr"}, ba, exp_br ? dma_addr : 16'h0000);
        chk({n, ".dma_done"}, {15'd0, done}, {15'd0, m.done});
        chk({n, ".dma_rdata"}, {8'd0, rd}, {8'd0, m.rdata});
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            cmp("A", ma, rdy_a, busy_a, br_a, ba_a, done_a, rdata_a);
            cmp("B", mb, rdy_b, busy_b, br_b, ba_b, done_b, rdata_b);
            if (cpu_en && !rdy_a) low_a++;
            if (cpu_en && !rdy_b) low_b++;
            if (cpu_en && br_a) begin rd_a++; last_addr_a = ba_a; end
            if (cpu_en && br_b) rd_b++;
            if (done_a) dn_a++;
            if (done_b) dn_b++;
        end
    end

    // Drives one DMC request on both instances; writes = CPU write cycles seen in HALT,
    // drop_at = CPU-cycle index at which the request is withdrawn (-1: never).
    task automatic run_fetch(input string tn, input logic [15:0] addr, input logic [7:0] data,
                             input bit gc, input int writes, input int drop_at, input bit gap,
                             input int exp_low_a, input int exp_low_b, input int exp_reads);
        int l0a, l0b, r0a, r0b, d0a, d0b, k;
        bit act_a, act_b, fin, en, dropped;
        l0a = low_a; l0b = low_b; r0a = rd_a; r0b = rd_b; d0a = dn_a; d0b = dn_b;
        act_a = 1; act_b = 1; k = 0; fin = 0;
        dma_addr = addr; bus_rdata = data; get_cycle = gc;
        for (int c = 0; c < 80 && !fin; c++) begin
            en = gap ? (c % 2 == 1) : 1'b1;
            dropped = (drop_at >= 0) && (k >= drop_at);
            cpu_en = en;
            cpu_read = !(k >= 1 && k <= writes);
            req_a = act_a && !dropped;
            req_b = act_b && !dropped;
            @(posedge clk); #1;
            if (done_a) act_a = 0;
            if (done_b) act_b = 0;
            if (en) k++;
            fin = (!act_a || dropped) && (!act_b || dropped);
        end
        if (!fin) begin
            checks++; errors++;
            $display("FAIL %s.timeout: got no completion expected done within 80 clks", tn);
        end
        req_a = 0; req_b = 0; cpu_en = 1; cpu_read = 1;
        repeat (4) begin @(posedge clk); #1; end
        chk({tn, ".stall_a"}, 16'(low_a - l0a), 16'(exp_low_a));
        chk({tn, ".stall_b"}, 16'(low_b - l0b), 16'(exp_low_b));
        chk({tn, ".reads_a"}, 16'(rd_a - r0a), 16'(exp_reads));
        chk({tn, ".reads_b"}, 16'(rd_b - r0b), 16'(exp_reads));
        chk({tn, ".dones_a"}, 16'(dn_a - d0a), 16'(exp_reads));
        chk({tn, ".dones_b"}, 16'(dn_b - d0b), 16'(exp_reads));
        if (exp_reads != 0) begin
            chk({tn, ".rdata_a"}, {8'd0, rdata_a}, {8'd0, data});
            chk({tn, ".rdata_b"}, {8'd0, rdata_b}, {8'd0, data});
            chk({tn, ".addr_a"}, last_addr_a, addr);
        end
    endtask

    initial begin
        reset = 1;
        repeat (2) begin @(posedge clk); #1; end
        chk("rst.rdy", {15'd0, rdy_a}, 16'd1);
        chk("rst.busy", {15'd0, busy_a}, 16'd0);
        chk("rst.done", {15'd0, done_a}, 16'd0);
        chk("rst.rdata", {8'd0, rdata_a}, 16'd0);
        chk("rst.bus_read", {15'd0, br_a}, 16'd0);
        chk("rst.bus_addr", ba_a, 16'h0000);
        reset = 0;
        cpu_en = 1; cpu_read = 1;
        repeat (2) begin @(posedge clk); #1; end

        run_fetch("t1", 16'hC040, 8'hA5, 1'b1, 0, -1, 1'b0, 3, 3, 1);
        run_fetch("t2", 16'hC123, 8'h5A, 1'b0, 0, -1, 1'b1, 4, 3, 1);
        run_fetch("t4", 16'hD000, 8'h3C, 1'b1, 2, -1, 1'b0, 5, 5, 1);
        run_fetch("t5a", 16'hE000, 8'h11, 1'b1, 5, 1, 1'b0, 1, 1, 0);
        run_fetch("t5b", 16'hE100, 8'h96, 1'b0, 0, 3, 1'b0, 4, 3, 1);

        // Reset pulse while both instances sit in GET with cpu_en low.
        dma_addr = 16'h8000; bus_rdata = 8'h77; get_cycle = 1; cpu_read = 1;
        cpu_en = 1; req_a = 1; req_b = 1;
        repeat (3) begin @(posedge clk); #1; end
        cpu_en = 0;
        chk("t6.in_get_a", {15'd0, br_a}, 16'd1);
        chk("t6.in_get_b", {15'd0, br_b}, 16'd1);
        #1 reset = 1;
        #1;
        chk("t6.rdy_a", {15'd0, rdy_a}, 16'd1);
        chk("t6.done_a", {15'd0, done_a}, 16'd0);
        chk("t6.rdata_a", {8'd0, rdata_a}, 16'd0);
        chk("t6.rdy_b", {15'd0, rdy_b}, 16'd1);
        chk("t6.rdata_b", {8'd0, rdata_b}, 16'd0);
        reset = 0;
        req_a = 0; req_b = 0;
        @(posedge clk); #1;
        cpu_en = 1;
        @(posedge clk); #1;
        chk("t6.nodone_a", {15'd0, done_a}, 16'd0);
        chk("t6.nodone_b", {15'd0, done_b}, 16'd0);
        run_fetch("t6n", 16'hC0FF, 8'hC3, 1'b1, 0, -1, 1'b0, 3, 3, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
